// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and sizing helper for the sequence player
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WAIT
    } seq_state_t;

    // Bits needed to hold the values 0..n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: down-counter whose done is high in the TICK_CYCLES-th cycle after start
module seq_timer #(
    parameter int TICK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int TW = $clog2(TICK_CYCLES + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Reload on start, otherwise count down and park at zero
    always_comb begin
        cnt_d = start ? TW'(TICK_CYCLES) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/seq_player.sv
// seq_player: records a short sequence of entries and plays it back at a fixed tick rate
module seq_player
    import seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int TICK_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       save,
    input  logic                       execute,
    input  logic                       stop,
    input  logic                       clear,
    input  logic                       loop_en,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       busy,
    output logic                       save_err
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    seq_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              serr_q, serr_d;
    logic              we;
    logic              t_start;
    logic              t_done;
    logic              is_full;

    logic [DATA_W-1:0] mem [DEPTH];

    seq_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .start(t_start),
        .done (t_done)
    );

    assign is_full = (count_q == CW'(DEPTH));

    // Next-state logic: clear beats execute beats save in IDLE; stop beats everything while busy
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        serr_d  = 1'b0;
        we      = 1'b0;
        t_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (execute) begin
                    if (count_q != '0) begin
                        state_d = PLAY;
                        idx_d   = '0;
                    end
                end else if (save) begin
                    if (is_full) begin
                        serr_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    dout_d  = mem[idx_q[AW-1:0]];
                    dv_d    = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    t_start = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (t_done) begin
                    if (idx_q < count_q) begin
                        state_d = PLAY;
                    end else if (loop_en) begin
                        idx_d   = '0;
                        state_d = PLAY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset also forgets the stored sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            serr_q  <= serr_d;
        end
    end

    // Entry storage; contents are meaningless until count covers them, so no reset
    always_ff @(posedge clk) begin
        if (we) mem[count_q[AW-1:0]] <= data_in;
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = is_full;
    assign busy       = (state_q != IDLE);
    assign save_err   = serr_q;

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: scoreboard bench for seq_player with DEPTH=4, TICK_CYCLES=4
module tb_seq_player;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       save = 1'b0;
    logic       execute = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       busy;
    logic       save_err;

    seq_player #(
        .DATA_W(8),
        .DEPTH(4),
        .TICK_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .save      (save),
        .execute   (execute),
        .stop      (stop),
        .clear     (clear),
        .loop_en   (loop_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .save_err  (save_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_strobe = 0;
    int   serr_cnt = 0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input int gap);
        exp_t x;
        x.d   = d;
        x.gap = gap;
        q.push_back(x);
    endtask

    // Monitor: every strobe must match the head of the expected queue and its spacing
    initial begin
        forever begin
            @(negedge clk);
            if (reset && save_err) serr_cnt++;
            if (reset && data_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: data_out=%0h with none expected", data_out);
                end else begin
                    e = q.pop_front();
                    chk("strobe_data", 32'(data_out), 32'(e.d));
                    if (e.gap != 0) chk("strobe_gap", cyc - last_strobe, e.gap);
                end
                last_strobe = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_save(input logic [7:0] d);
        save    = 1'b1;
        data_in = d;
        tick();
        save = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_exec();
        execute = 1'b1;
        tick();
        execute = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_q();
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        chk("strobe_timeout", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held low
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_serr", 32'(save_err), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic record and single playback
        do_save(8'h11);
        do_save(8'h22);
        do_save(8'h33);
        chk("s1_count", 32'(count), 3);
        push(8'h11, 0);
        push(8'h22, 5);
        push(8'h33, 5);
        do_exec();
        chk("s1_busy", 32'(busy), 1);
        wait_idle();
        wait_q();
        chk("s1_hold", 32'(data_out), 32'h33);
        chk("s1_count_after", 32'(count), 3);

        // Overfill: fifth save rejected, buffer content intact
        do_clear();
        chk("s2_cleared", 32'(count), 0);
        serr_cnt = 0;
        do_save(8'hA1);
        do_save(8'hA2);
        do_save(8'hA3);
        do_save(8'hA4);
        do_save(8'hA5);
        chk("s2_count", 32'(count), 4);
        chk("s2_full", 32'(full), 1);
        tick();
        tick();
        chk("s2_serr_pulses", serr_cnt, 1);
        push(8'hA1, 0);
        push(8'hA2, 5);
        push(8'hA3, 5);
        push(8'hA4, 5);
        do_exec();
        wait_idle();
        wait_q();

        // Looping playback stopped mid-WAIT
        do_clear();
        do_save(8'h11);
        do_save(8'h22);
        loop_en = 1'b1;
        push(8'h11, 0);
        push(8'h22, 5);
        push(8'h11, 5);
        push(8'h22, 5);
        do_exec();
        wait_q();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s3_stop_idle", 32'(busy), 0);
        loop_en = 1'b0;
        repeat (15) tick();
        chk("s3_count", 32'(count), 2);

        // Execute while empty, then save+execute together
        do_clear();
        do_exec();
        chk("s4_empty_exec_busy", 32'(busy), 0);
        chk("s4_empty_exec_count", 32'(count), 0);
        do_save(8'h55);
        save    = 1'b1;
        execute = 1'b1;
        data_in = 8'h66;
        tick();
        save    = 1'b0;
        execute = 1'b0;
        chk("s4_busy", 32'(busy), 1);
        chk("s4_count", 32'(count), 1);
        push(8'h55, 0);
        wait_idle();
        wait_q();
        chk("s4_count_after", 32'(count), 1);

        // Clear in IDLE, then clear ignored during PLAY
        do_clear();
        do_save(8'h01);
        do_save(8'h02);
        do_save(8'h03);
        chk("s5_count3", 32'(count), 3);
        do_clear();
        chk("s5_clear_count", 32'(count), 0);
        chk("s5_clear_empty", 32'(empty), 1);
        do_save(8'h77);
        do_save(8'h88);
        push(8'h77, 0);
        push(8'h88, 5);
        do_exec();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("s5_play_clear_count", 32'(count), 2);
        chk("s5_play_clear_busy", 32'(busy), 1);
        wait_idle();
        wait_q();
        chk("s5_count_after", 32'(count), 2);

        // Asynchronous reset during WAIT
        do_clear();
        do_save(8'h99);
        push(8'h99, 0);
        do_exec();
        wait_q();
        #2;
        reset = 1'b0;
        #1;
        chk("s6_count", 32'(count), 0);
        chk("s6_empty", 32'(empty), 1);
        chk("s6_full", 32'(full), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_dv", 32'(data_valid), 0);
        chk("s6_dout", 32'(data_out), 0);
        chk("s6_serr", 32'(save_err), 0);
        #10;
        reset = 1'b1;
        repeat (8) tick();
        chk("s6_post_busy", 32'(busy), 0);
        chk("s6_post_count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of a recorded entry.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of storable entries (power of two, >=2).
REQ-003 The block SHALL have parameter TICK_CYCLES, default 1000, meaning the number of clk cycles spent in WAIT between entries (>=1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port save, input, 1, a level that records data_in on each cycle it is high in IDLE.
REQ-007 The block SHALL have port execute, input, 1, which starts playback.
REQ-008 The block SHALL have port stop, input, 1, which aborts playback.
REQ-009 The block SHALL have port clear, input, 1, which empties the buffer.
REQ-010 The block SHALL have port loop_en, input, 1, which enables wrap-around playback.
REQ-011 The block SHALL have port data_in, input, DATA_W, the entry to record.
REQ-012 The block SHALL have port data_out, output, DATA_W, the entry currently being played.
REQ-013 The block SHALL have port data_valid, output, 1, a one-cycle strobe marking a new data_out.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1), the number of stored entries.
REQ-015 The block SHALL have ports empty and full, outputs, 1 each: empty = (count==0), full = (count==DEPTH).
REQ-016 The block SHALL have port busy, output, 1, high in PLAY or WAIT.
REQ-017 The block SHALL have port save_err, output, 1, a one-cycle pulse on a rejected save.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, PLAY and WAIT.
REQ-019 In IDLE with save=1, execute=0, clear=0 and not full, mem[count] SHALL take data_in and count SHALL increment by 1 next cycle.
REQ-020 A save in IDLE while full SHALL leave the buffer unchanged and pulse save_err for one cycle.
REQ-021 Saves SHALL be ignored (no write, no save_err) in PLAY or WAIT.
REQ-022 In IDLE, clear=1 SHALL set count to 0 next cycle and take priority over save and execute.
REQ-023 In IDLE, execute=1 with count>0 SHALL move to PLAY next cycle with play index 0, and SHALL take priority over save.
REQ-024 execute with count==0 SHALL be ignored.
REQ-025 Each PLAY cycle SHALL register data_out=mem[index], assert data_valid for exactly that one cycle, increment index, and move to WAIT.
REQ-026 WAIT SHALL last exactly TICK_CYCLES cycles, so successive data_valid pulses are TICK_CYCLES+1 cycles apart.
REQ-027 On WAIT expiry, if index<count the FSM SHALL go to PLAY.
REQ-028 On WAIT expiry, if index==count and loop_en=1 (sampled at expiry), the FSM SHALL set index to 0 and go to PLAY.
REQ-029 On WAIT expiry, if index==count and loop_en=0, the FSM SHALL go to IDLE.
REQ-030 Playback SHALL be non-destructive: count and mem are unchanged by playback.
REQ-031 stop=1 in PLAY or WAIT SHALL force IDLE next cycle with no further data_valid.
REQ-032 stop SHALL beat execute when both are asserted.
REQ-033 execute and clear SHALL be ignored while busy.
REQ-034 data_out SHALL hold its last value between strobes and after playback ends.

Reset
REQ-035 While reset=0, outputs SHALL be: state IDLE, count 0, index 0, timer 0, data_out 0, data_valid 0, save_err 0, busy 0, empty 1, full 0.
REQ-036 Reset mid-playback SHALL abort immediately and discard the buffer contents (count=0).
REQ-037 mem SHALL NOT require reset.

Structure
REQ-038 State typedef seq_state_t (IDLE, PLAY, WAIT) SHALL reside in package seq_pkg.
REQ-039 The WAIT interval counter SHALL be sub-module seq_timer (inputs clk, reset, start, parameter TICK_CYCLES; output done), pulsing done after exactly TICK_CYCLES cycles.

Verification (DATA_W=8, DEPTH=4, TICK_CYCLES=4)
REQ-040 The bench SHALL cover this scenario: save 0x11,0x22,0x33 on three cycles, then execute -> count=3; data_valid with 0x11,0x22,0x33 five cycles apart; busy=0 after last WAIT.
REQ-041 The bench SHALL cover this scenario: save 5 values -> count=4, full=1, save_err pulses once on the 5th save, and mem is unchanged.
REQ-042 The bench SHALL cover this scenario: loop_en=1 with 2 entries -> sequence 0x11,0x22,0x11,0x22…; stop mid-WAIT -> IDLE next cycle with no further strobes.
REQ-043 The bench SHALL cover these scenarios: execute when empty -> stays IDLE; save+execute together with count>0 -> playback starts and count is unchanged.
REQ-044 The bench SHALL cover this scenario: reset low during WAIT -> all outputs at reset values in the same cycle, empty=1.
REQ-045 The bench SHALL cover this scenario: clear in IDLE with count=3 -> count=0 and empty=1 next cycle; clear during PLAY -> ignored.
